adaptation_scheduler: RTL and testbench

//  Parametrised equaliser adaptation sequencer: STARTUP -> CMA -> LMS with per-phase step size (mu) output.

---
 rtl/adapt_pkg.sv | 12 +
 rtl/adaptation_scheduler_if.sv | 42 ++++
 rtl/adapt_sat_counter.sv | 20 ++
 rtl/adaptation_scheduler.sv | 168 ++++++++++++++++
 tb/tb_adaptation_scheduler.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/adapt_pkg.sv
// Shared phase encoding and widths for the equaliser adaptation scheduler.
package adapt_pkg;

    typedef enum logic [1:0] {
        PH_STARTUP = 2'd0,
        PH_CMA     = 2'd1,
        PH_LMS     = 2'd2
    } phase_e;

    localparam int FB_W = 8;

endpackage

// File: rtl/adaptation_scheduler_if.sv
// Control/config/status bundle between the sample front-end and the adaptation scheduler.
interface adaptation_scheduler_if
    import adapt_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int MU_W  = 16,
    parameter int ERR_W = 16
);
    logic             enable;
    logic             sample_valid;
    logic             freeze;
    logic             restart;
    logic [CNT_W-1:0] startup_delay;
    logic [CNT_W-1:0] cma_duration;
    logic [CNT_W-1:0] gear_period;
    logic [MU_W-1:0]  cma_mu;
    logic [MU_W-1:0]  lms_mu;
    logic [ERR_W-1:0] err_mag;
    logic [ERR_W-1:0] div_thresh;

    logic [1:0]       phase;
    logic             cma_en;
    logic             lms_en;
    logic [MU_W-1:0]  mu;
    logic [CNT_W-1:0] iteration_count;
    logic             phase_change;
    logic [FB_W-1:0]  fallback_count;

    modport slave (
        input  enable, sample_valid, freeze, restart,
        input  startup_delay, cma_duration, gear_period,
        input  cma_mu, lms_mu, err_mag, div_thresh,
        output phase, cma_en, lms_en, mu, iteration_count, phase_change, fallback_count
    );

    modport master (
        output enable, sample_valid, freeze, restart,
        output startup_delay, cma_duration, gear_period,
        output cma_mu, lms_mu, err_mag, div_thresh,
        input  phase, cma_en, lms_en, mu, iteration_count, phase_change, fallback_count
    );
endinterface

// File: rtl/adapt_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module adapt_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/adaptation_scheduler.sv
// STARTUP -> CMA -> LMS adaptation sequencer with mu gearing, freeze and restart.
// Optional LMS->CMA divergence fallback enabled by defining ADAPT_SCHED_DIVERGENCE_FALLBACK_EN.
module adaptation_scheduler
    import adapt_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MU_W     = 16,
    parameter int ERR_W    = 16,
    parameter int MAX_GEAR = 4,
    parameter int DIV_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    adaptation_scheduler_if.slave bus
);

    localparam int GEAR_W = $clog2(MAX_GEAR + 1);
    localparam int DIV_W  = $clog2(DIV_LEN + 1);

    phase_e            phase_q, phase_d;
    logic [GEAR_W-1:0] gear_q, gear_d;
    logic [MU_W-1:0]   mu_q, mu_d;
    logic              pc_q, pc_d;
    logic              cma_en_q, lms_en_q;
    logic [CNT_W-1:0]  cnt, sub;
    logic [CNT_W:0]    sub_next;
    logic              cnt_clr, cnt_inc, sub_clr, sub_inc;
    logic              adv;

    assign adv      = bus.enable & bus.sample_valid & ~bus.freeze;
    assign sub_next = {1'b0, sub} + (CNT_W + 1)'(1);

    adapt_sat_counter #(.W(CNT_W)) u_phase_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(cnt_inc), .count(cnt)
    );

    adapt_sat_counter #(.W(CNT_W)) u_gear_cnt (
        .clk(clk), .rst(rst), .clr(sub_clr), .inc(sub_inc), .count(sub)
    );

`ifdef ADAPT_SCHED_DIVERGENCE_FALLBACK_EN
    logic [DIV_W-1:0] div_run;
    logic [DIV_W:0]   div_next;
    logic             div_clr, div_inc, fb_inc;
    logic [FB_W-1:0]  fb_q;

    assign div_next = {1'b0, div_run} + (DIV_W + 1)'(1);

    adapt_sat_counter #(.W(DIV_W)) u_div_run (
        .clk(clk), .rst(rst), .clr(div_clr), .inc(div_inc), .count(div_run)
    );

    // Survives restart; only rst clears the fallback history.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_q <= '0;
        end else if (fb_inc && (fb_q != '1)) begin
            fb_q <= fb_q + FB_W'(1);
        end
    end

    assign bus.fallback_count = fb_q;
`else
    logic unused_div_inputs;
    assign unused_div_inputs  = ^{bus.err_mag, bus.div_thresh, DIV_W'(DIV_LEN)};
    assign bus.fallback_count = '0;
`endif

    always_comb begin
        phase_d = phase_q;
        gear_d  = gear_q;
        mu_d    = mu_q;
        pc_d    = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = adv;
        sub_clr = 1'b0;
        sub_inc = 1'b0;
`ifdef ADAPT_SCHED_DIVERGENCE_FALLBACK_EN
        div_clr = 1'b0;
        div_inc = 1'b0;
        fb_inc  = 1'b0;
`endif
        if (bus.restart) begin
            phase_d = PH_STARTUP;
            gear_d  = '0;
            mu_d    = '0;
            pc_d    = (phase_q != PH_STARTUP);
            cnt_clr = 1'b1;
            sub_clr = 1'b1;
`ifdef ADAPT_SCHED_DIVERGENCE_FALLBACK_EN
            div_clr = 1'b1;
`endif
        end else if (!bus.freeze) begin
            unique case (phase_q)
                PH_STARTUP: if (cnt >= bus.startup_delay) phase_d = PH_CMA;
                PH_CMA:     if (cnt >= bus.cma_duration)  phase_d = PH_LMS;
                PH_LMS: begin
                    if (adv) begin
                        // >= rather than == so a period lowered mid-LMS still steps
                        if (bus.gear_period == '0) begin
                            sub_clr = 1'b1;
                        end else if (sub_next >= {1'b0, bus.gear_period}) begin
                            sub_clr = 1'b1;
                            if (gear_q != GEAR_W'(MAX_GEAR)) gear_d = gear_q + GEAR_W'(1);
                        end else begin
                            sub_inc = 1'b1;
                        end
`ifdef ADAPT_SCHED_DIVERGENCE_FALLBACK_EN
                        if (bus.err_mag > bus.div_thresh) begin
                            if (div_next >= (DIV_W + 1)'(DIV_LEN)) begin
                                phase_d = PH_CMA;
                                fb_inc  = 1'b1;
                            end else begin
                                div_inc = 1'b1;
                            end
                        end else begin
                            div_clr = 1'b1;
                        end
`endif
                    end
                end
                default: phase_d = PH_STARTUP;
            endcase

            if (phase_d != phase_q) begin
                cnt_clr = 1'b1;
                sub_clr = 1'b1;
                gear_d  = '0;
`ifdef ADAPT_SCHED_DIVERGENCE_FALLBACK_EN
                div_clr = 1'b1;
`endif
            end
            pc_d = (phase_d != phase_q);

            unique case (phase_d)
                PH_STARTUP: mu_d = '0;
                PH_CMA:     mu_d = bus.cma_mu;
                default:    mu_d = bus.lms_mu >> gear_d;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_STARTUP;
            gear_q   <= '0;
            mu_q     <= '0;
            pc_q     <= 1'b0;
            cma_en_q <= 1'b0;
            lms_en_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            gear_q   <= gear_d;
            mu_q     <= mu_d;
            pc_q     <= pc_d;
            cma_en_q <= (phase_d == PH_CMA);
            lms_en_q <= (phase_d == PH_LMS);
        end
    end

    assign bus.phase           = phase_q;
    assign bus.cma_en          = cma_en_q;
    assign bus.lms_en          = lms_en_q;
    assign bus.mu              = mu_q;
    assign bus.iteration_count = cnt;
    assign bus.phase_change    = pc_q;

endmodule

// File: tb/tb_adaptation_scheduler.sv
// Directed + randomized bench for adaptation_scheduler against a cycle-level behavioural model.
module tb_adaptation_scheduler;

    localparam int CNT_W    = 32;
    localparam int MU_W     = 16;
    localparam int ERR_W    = 16;
    localparam int MAX_GEAR = 4;
    localparam int DIV_LEN  = 8;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
`ifdef ADAPT_SCHED_DIVERGENCE_FALLBACK_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adaptation_scheduler_if #(.CNT_W(CNT_W), .MU_W(MU_W), .ERR_W(ERR_W)) bus ();

    adaptation_scheduler #(
        .CNT_W(CNT_W), .MU_W(MU_W), .ERR_W(ERR_W), .MAX_GEAR(MAX_GEAR), .DIV_LEN(DIV_LEN)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int     n_vec = 0;
    int     n_err = 0;
    int     m_ph, m_gear, m_div, m_fb;
    longint m_cnt, m_sub, m_mu;
    bit     m_pc;
    int     n_pc, n_ph0, n_ph1;
    logic [CNT_W-1:0] saved_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the reference by one clock using the inputs currently applied.
    task automatic model_step();
        bit adv;
        bit fall;
        int nph;
        adv = bus.enable && bus.sample_valid && !bus.freeze;
        if (rst) begin
            m_ph = 0; m_cnt = 0; m_sub = 0; m_gear = 0; m_div = 0; m_fb = 0; m_mu = 0; m_pc = 0;
        end else if (bus.restart) begin
            m_pc = (m_ph != 0);
            m_ph = 0; m_cnt = 0; m_sub = 0; m_gear = 0; m_div = 0; m_mu = 0;
        end else if (bus.freeze) begin
            m_pc = 0;
        end else begin
            nph  = m_ph;
            fall = 0;
            if (m_ph == 0 && m_cnt >= longint'(bus.startup_delay)) nph = 1;
            else if (m_ph == 1 && m_cnt >= longint'(bus.cma_duration)) nph = 2;
            else if (m_ph == 2 && adv) begin
                if (bus.gear_period == 0) m_sub = 0;
                else if (m_sub + 1 >= longint'(bus.gear_period)) begin
                    m_sub = 0;
                    if (m_gear < MAX_GEAR) m_gear++;
                end else m_sub++;
                if (DIV_ON) begin
                    if (bus.err_mag > bus.div_thresh) begin
                        if (m_div + 1 >= DIV_LEN) fall = 1;
                        else m_div++;
                    end else m_div = 0;
                end
            end
            if (fall) begin
                nph = 1;
                if (m_fb < 255) m_fb++;
            end
            if (nph != m_ph) begin
                m_cnt = 0; m_sub = 0; m_gear = 0; m_div = 0;
            end else if (adv && m_cnt < CNT_MAX) m_cnt++;
            m_pc = (nph != m_ph);
            m_ph = nph;
            m_mu = (m_ph == 0) ? 0 : (m_ph == 1) ? longint'(bus.cma_mu) : longint'(bus.lms_mu >> m_gear);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("phase", 64'(bus.phase), 64'(m_ph));
        chk("cma_en", 64'(bus.cma_en), 64'(m_ph == 1));
        chk("lms_en", 64'(bus.lms_en), 64'(m_ph == 2));
        chk("mu", 64'(bus.mu), 64'(m_mu));
        chk("iteration_count", 64'(bus.iteration_count), 64'(m_cnt));
        chk("phase_change", 64'(bus.phase_change), 64'(m_pc));
        chk("fallback_count", 64'(bus.fallback_count), 64'(m_fb));
        if (bus.phase_change === 1'b1) n_pc++;
        if (bus.phase === 2'd0) n_ph0++;
        if (bus.phase === 2'd1) n_ph1++;
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
    endtask

    initial begin
        bus.enable = 1'b0; bus.sample_valid = 1'b0; bus.freeze = 1'b0; bus.restart = 1'b0;
        bus.startup_delay = '0; bus.cma_duration = '0; bus.gear_period = '0;
        bus.cma_mu = '0; bus.lms_mu = '0; bus.err_mag = '0; bus.div_thresh = '0;
        tick();
        tick();
        rst = 1'b0;

        // Nominal sequence: 4 cycles STARTUP, 6 cycles CMA, then LMS.
        bus.startup_delay = 3; bus.cma_duration = 5;
        bus.cma_mu = 16'h0040; bus.lms_mu = 16'h0100;
        bus.enable = 1'b1; bus.sample_valid = 1'b1;
        n_pc = 0; n_ph0 = 1; n_ph1 = 0;   // the reset cycle already showed STARTUP
        for (int i = 0; i < 14; i++) tick();
        chk("t1_startup_cycles", 64'(n_ph0), 64'd4);
        chk("t1_cma_cycles", 64'(n_ph1), 64'd6);
        chk("t1_pulses", 64'(n_pc), 64'd2);

        // Valid gating: 4 valid samples over 8 cycles.
        bus.startup_delay = 4; bus.cma_duration = 1000;
        do_restart();
        for (int i = 0; i < 8; i++) begin
            bus.sample_valid = (i % 2 == 0);
            tick();
        end
        chk("t2_cma_after_8", 64'(bus.phase), 64'd1);
        bus.sample_valid = 1'b1;

        // Gearing: mu halves every 10 LMS samples, holding at lms_mu>>MAX_GEAR.
        bus.startup_delay = 0; bus.cma_duration = 0; bus.gear_period = 10;
        do_restart();
        for (int i = 0; i < 12; i++) tick();
        chk("t3_mu_gear1", 64'(bus.mu), 64'h0080);
        for (int i = 0; i < 50; i++) tick();
        chk("t3_mu_floor", 64'(bus.mu), 64'h0010);

        // Freeze mid-CMA, then restart while still frozen.
        bus.startup_delay = 2; bus.cma_duration = 40;
        do_restart();
        for (int i = 0; i < 8; i++) tick();
        saved_cnt = bus.iteration_count;
        bus.freeze = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.sample_valid = $urandom_range(0, 1);
            tick();
        end
        chk("t4_freeze_hold", 64'(bus.iteration_count), 64'(saved_cnt));
        bus.sample_valid = 1'b1;
        do_restart();
        chk("t4_restart_phase", 64'(bus.phase), 64'd0);
        chk("t4_restart_count", 64'(bus.iteration_count), 64'd0);
        chk("t4_restart_pulse", 64'(bus.phase_change), 64'd1);
        bus.freeze = 1'b0;

`ifdef ADAPT_SCHED_DIVERGENCE_FALLBACK_EN
        // Divergence: a broken run of 7 does not trigger; a full run of 8 does.
        bus.startup_delay = 0; bus.cma_duration = 0; bus.gear_period = 0;
        bus.div_thresh = 100; bus.err_mag = 0;
        do_restart();
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            bus.err_mag = (i == 7) ? 16'd50 : 16'd200;
            if (i == 15) bus.cma_duration = 1000;
            tick();
        end
        chk("t5_fallback_phase", 64'(bus.phase), 64'd1);
        chk("t5_fallback_count", 64'(bus.fallback_count), 64'd1);
`endif

        // Randomized traffic with live config changes.
        bus.cma_mu = 16'($urandom); bus.lms_mu = 16'($urandom);
        bus.gear_period = 3; bus.div_thresh = 100;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                bus.startup_delay = $urandom_range(0, 12);
                bus.cma_duration  = $urandom_range(0, 12);
            end
            bus.sample_valid = ($urandom_range(0, 3) != 0);
            bus.enable       = ($urandom_range(0, 7) != 0);
            bus.freeze       = ($urandom_range(0, 15) == 0);
            bus.restart      = ($urandom_range(0, 63) == 0);
            bus.err_mag      = $urandom_range(0, 200);
            rst              = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; bus.freeze = 1'b0; bus.restart = 1'b0;

        // Reset beats freeze mid-LMS.
        bus.enable = 1'b1; bus.sample_valid = 1'b1; bus.err_mag = 0;
        bus.startup_delay = 0; bus.cma_duration = 0;
        do_restart();
        for (int i = 0; i < 4; i++) tick();
        chk("t6_in_lms", 64'(bus.phase), 64'd2);
        bus.freeze = 1'b1;
        rst = 1'b1;
        tick();
        chk("t6_rst_phase", 64'(bus.phase), 64'd0);
        chk("t6_rst_mu", 64'(bus.mu), 64'd0);
        chk("t6_rst_lms_en", 64'(bus.lms_en), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
